// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port tags, arbiter states and
// the default starvation bound.
package dmem_arbiter_pkg;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    localparam int unsigned MAX_WAIT_DEFAULT = 4;
    localparam int unsigned WAIT_CNT_W       = 4;

    typedef enum logic {
        StArb    = 1'b0,
        StLocked = 1'b1
    } arb_state_e;

    function automatic logic [WAIT_CNT_W-1:0] sat_inc(
        input logic [WAIT_CNT_W-1:0] val,
        input logic [WAIT_CNT_W-1:0] lim
    );
        return (val >= lim) ? lim : val + WAIT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: core has fixed priority, debug
// is protected by a starvation counter and can take exclusive ownership.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_c_req,
    input  logic              i_c_we,
    input  logic [31:0]       i_c_addr,
    input  logic [3:0]        i_c_be,
    input  logic [DATA_W-1:0] i_c_wdata,
    output logic              o_c_gnt,
    output logic              o_c_rvalid,
    output logic [DATA_W-1:0] o_c_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [31:0]       i_d_addr,
    input  logic [3:0]        i_d_be,
    input  logic [DATA_W-1:0] i_d_wdata,
    input  logic              i_d_lock,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_locked,
    output logic              o_mem_en,
    output logic [3:0]        o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [WAIT_CNT_W-1:0] MaxWait = WAIT_CNT_W'(MAX_WAIT);

    arb_state_e            r_state;
    arb_state_e            w_state_next;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_next;
    logic                  r_rsp_valid;
    logic                  r_rsp_owner;
    logic [DATA_W-1:0]     r_c_rdata;
    logic [DATA_W-1:0]     r_d_rdata;

    logic w_c_gnt;
    logic w_d_gnt;
    logic w_gnt_read;
    logic w_c_rsp;
    logic w_d_rsp;
    logic w_unused;

    // Grants are masked while reset is asserted so nothing reaches memory.
    always_comb begin
        w_c_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (i_rst_n) begin
            unique case (r_state)
                StArb: begin
                    if (r_wait_cnt == MaxWait && i_d_req) begin
                        w_d_gnt = 1'b1;
                    end else if (i_c_req) begin
                        w_c_gnt = 1'b1;
                    end else if (i_d_req) begin
                        w_d_gnt = 1'b1;
                    end
                end
                StLocked: w_d_gnt = i_d_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StArb: begin
                if (w_d_gnt && i_d_lock) begin
                    w_state_next = StLocked;
                end
            end
            StLocked: begin
                if (!i_d_lock && !i_d_req) begin
                    w_state_next = StArb;
                end
            end
            default: w_state_next = StArb;
        endcase
    end

    always_comb begin
        w_wait_cnt_next = '0;
        if (i_d_req && !w_d_gnt) begin
            w_wait_cnt_next = sat_inc(r_wait_cnt, MaxWait);
        end
    end

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 4'b0000;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_c_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_c_we ? i_c_be : 4'b0000;
            o_mem_addr  = i_c_addr[ADDR_W+1:2];
            o_mem_wdata = i_c_wdata;
        end else if (w_d_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_d_we ? i_d_be : 4'b0000;
            o_mem_addr  = i_d_addr[ADDR_W+1:2];
            o_mem_wdata = i_d_wdata;
        end
    end

    assign w_gnt_read = (w_c_gnt && !i_c_we) || (w_d_gnt && !i_d_we);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StArb;
            r_wait_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_owner <= PORT_CORE;
            r_c_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_rsp_valid <= w_gnt_read;
            if (w_gnt_read) begin
                r_rsp_owner <= w_d_gnt ? PORT_DBG : PORT_CORE;
            end
            // Capture delivered data so each port's rdata holds between responses.
            if (w_c_rsp) begin
                r_c_rdata <= i_mem_rdata;
            end
            if (w_d_rsp) begin
                r_d_rdata <= i_mem_rdata;
            end
        end
    end

    assign w_c_rsp = r_rsp_valid && (r_rsp_owner == PORT_CORE);
    assign w_d_rsp = r_rsp_valid && (r_rsp_owner == PORT_DBG);

    assign o_c_gnt    = w_c_gnt;
    assign o_d_gnt    = w_d_gnt;
    assign o_c_rvalid = i_rst_n && w_c_rsp;
    assign o_d_rvalid = i_rst_n && w_d_rsp;
    assign o_c_rdata  = !i_rst_n ? '0 : (w_c_rsp ? i_mem_rdata : r_c_rdata);
    assign o_d_rdata  = !i_rst_n ? '0 : (w_d_rsp ? i_mem_rdata : r_d_rdata);
    assign o_locked   = i_rst_n && (r_state == StLocked);

    assign w_unused = ^{i_c_addr[31:ADDR_W+2], i_c_addr[1:0],
                        i_d_addr[31:ADDR_W+2], i_d_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter with a behavioural memory and a
// rule-level reference model of arbitration and memory contents.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
    logic [3:0]  c_be, d_be;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid, locked, mem_en;
    logic [31:0] c_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_be(c_be),
        .i_c_wdata(c_wdata), .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_be(d_be),
        .i_d_wdata(d_wdata), .i_d_lock(d_lock), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid),
        .o_d_rdata(d_rdata), .o_locked(locked), .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: synchronous single-port RAM with byte writes.
    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model state.
    logic [31:0] refmem [1024];
    bit          m_locked = 0;
    int          m_wait = 0;
    typedef struct {int cyc; bit port; logic [31:0] data;} rsp_t;
    rsp_t        rsp_q[$];
    logic [31:0] last_c = 0, last_d = 0;

    task automatic set_c(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        c_req = req; c_we = we; c_addr = addr; c_be = be; c_wdata = wd;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input logic lock);
        d_req = req; d_we = we; d_addr = addr; d_be = be; d_wdata = wd; d_lock = lock;
    endtask

    task automatic idle();
        set_c(0, 0, 0, 0, 0);
        set_d(0, 0, 0, 0, 0, 0);
    endtask

    // One cycle: check grants and memory drive against the model, then advance it.
    task automatic tick();
        bit          eg_c, eg_d, we;
        logic [31:0] addr, wd;
        logic [3:0]  be;
        int          idx;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_gnt", {c_gnt, d_gnt, locked, mem_en}, 0);
            chk("rst_mem", {mem_we, 18'd0, mem_addr}, 0);
            chk("rst_wdata", mem_wdata, 0);
            m_locked = 0;
            m_wait = 0;
        end else begin
            eg_c = 0;
            eg_d = 0;
            if (m_locked) eg_d = d_req;
            else if (m_wait == MAX_WAIT && d_req) eg_d = 1;
            else if (c_req) eg_c = 1;
            else if (d_req) eg_d = 1;
            chk("c_gnt", c_gnt, eg_c);
            chk("d_gnt", d_gnt, eg_d);
            chk("locked", locked, m_locked);
            chk("mem_en", mem_en, eg_c | eg_d);
            if (eg_c || eg_d) begin
                we = eg_c ? c_we : d_we;
                addr = eg_c ? c_addr : d_addr;
                be = eg_c ? c_be : d_be;
                wd = eg_c ? c_wdata : d_wdata;
                idx = (addr / 4) % 1024;
                chk("mem_addr", mem_addr, idx);
                chk("mem_we", mem_we, we ? be : 4'h0);
                chk("mem_wdata", mem_wdata, wd);
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) refmem[idx][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    rsp_q.push_back('{cyc: cyc + 1, port: eg_d, data: refmem[idx]});
                end
            end else begin
                chk("mem_we_idle", mem_we, 0);
            end
            m_wait = (d_req && !eg_d) ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
            if (!m_locked && eg_d && d_lock) m_locked = 1;
            else if (m_locked && !d_lock && !d_req) m_locked = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected read responses and checks read-data hold behaviour.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rvalid", {c_rvalid, d_rvalid}, 0);
            chk("rst_c_rdata", c_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            last_c = 0;
            last_d = 0;
            while (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) void'(rsp_q.pop_front());
        end else if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
            rsp_t e;
            e = rsp_q.pop_front();
            if (!e.port) begin
                chk("c_rvalid", {c_rvalid, d_rvalid}, 2'b10);
                chk("c_rdata", c_rdata, e.data);
                chk("d_rdata_hold", d_rdata, last_d);
                last_c = e.data;
            end else begin
                chk("d_rvalid", {c_rvalid, d_rvalid}, 2'b01);
                chk("d_rdata", d_rdata, e.data);
                chk("c_rdata_hold", c_rdata, last_c);
                last_d = e.data;
            end
        end else begin
            chk("no_rvalid", {c_rvalid, d_rvalid}, 0);
            chk("c_rdata_idle", c_rdata, last_c);
            chk("d_rdata_idle", d_rdata, last_d);
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = 0;
            refmem[i] = 0;
        end
        mem_rdata = 0;
        rst_n = 0;
        set_c(1, 0, 0, 0, 0);
        set_d(1, 0, 0, 0, 0, 0);
        repeat (3) tick();
        rst_n = 1;
        idle();
        tick();

        // Read latency after a debug write.
        set_d(1, 1, 32'h0, 4'hF, 32'h1234_5678, 0);
        tick();
        idle();
        set_c(1, 0, 32'h0, 4'h0, 0);
        tick();
        idle();
        tick();

        // Partial byte write.
        set_d(1, 1, 32'h4, 4'hF, 32'h9ABC_DEF0, 0);
        tick();
        idle();
        set_c(1, 1, 32'h4, 4'h1, 32'h0000_00AA);
        tick();
        set_c(1, 0, 32'h4, 4'h0, 0);
        tick();
        idle();
        tick();

        // Starvation: both requesting continuously.
        set_c(1, 0, 32'h4, 4'h0, 0);
        set_d(1, 0, 32'h0, 4'h0, 0, 0);
        repeat (15) tick();

        // Lock: debug reads three words while core keeps requesting.
        idle();
        tick();
        set_c(1, 0, 32'h0, 4'h0, 0);
        for (int i = 0; i < 6; i++) begin
            set_d((i % 2) == 0, 0, 32'(4 * (i / 2)), 4'h0, 0, 1);
            tick();
        end
        set_d(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Address wrap beyond 4 KiB, and a zero-byte-enable write.
        set_c(1, 1, 32'h1000, 4'h1, 32'h11);
        tick();
        set_c(1, 1, 32'h0, 4'h0, 32'hFFFF_FFFF);
        tick();
        set_c(1, 0, 32'h0, 4'h0, 0);
        tick();
        idle();
        tick();

        // Reset with a read in flight drops the response.
        set_d(1, 0, 32'h4, 4'h0, 0, 0);
        tick();
        rst_n = 0;
        idle();
        tick();
        tick();
        rst_n = 1;
        tick();

        // Randomised traffic over a small address window with random upper bits.
        for (int i = 0; i < 600; i++) begin
            set_c(($urandom % 4) != 0, $urandom % 2, $urandom & 32'hFFFF_F03F,
                  4'($urandom), $urandom);
            set_d(($urandom % 2) != 0, $urandom % 2, $urandom & 32'hFFFF_F03F,
                  4'($urandom), $urandom,
                  m_locked ? (($urandom % 2) != 0) : (($urandom % 8) == 0));
            tick();
        end
        idle();
        repeat (3) tick();
        chk("rsp_drain", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
